regfile_stream_port: RTL and testbench
======================================

# regfile_stream_port

Sequencing initiator for the 8x8 register file's write and read ports. It bulk-loads all eight registers from an incoming byte stream, or dumps all eight over an outgoing byte stream, using valid/ready handshakes on both streams. It sits between a host/debug byte channel and the register file, and shares that file's write port and one of its read ports.

## Interface
Parameters:
- none. Register count (8) and width (8) are fixed to match the register file.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  command select, sampled with start: 0 = LOAD, 1 = DUMP
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a command completes
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  high exactly when state is LOAD
- out_valid  out  1  output byte valid
- out_data  out  8  output byte
- out_ready  in  1  downstream accepts the byte
- rf_WriteEN  out  1  register file write enable
- rf_Write_Address  out  3  register file write address
- rf_Write_Data  out  8  register file write data
- rf_Read_Address  out  3  register file read address
- rf_Read_Data  in  8  combinational read data for rf_Read_Address

## Operation
- Single clock CLK; reset is synchronous and active-high on RST.
- States: IDLE, LOAD, DUMP, CSUM (present only with the macro), DRAIN.
- Keep a 3-bit index idx and an 8-bit checksum accumulator csum.
- IDLE:
  - start=1 clears idx and csum.
  - Goes to LOAD if mode=0, DUMP if mode=1.
- LOAD:
  - rf_WriteEN = in_valid (combinational).
  - rf_Write_Address = idx; rf_Write_Data = in_data.
  - Each in_valid&in_ready handshake writes one register and increments idx.
  - The handshake at idx=7 returns the block to IDLE.
- DUMP:
  - rf_Read_Address = idx.
  - When out_valid=0 or out_ready=1: load out_data from rf_Read_Data, set out_valid=1, set csum ^= rf_Read_Data, increment idx.
  - The load at idx=7 goes to CSUM (macro defined) or DRAIN (otherwise).
- CSUM: when out_valid=0 or out_ready=1, load csum into out_data, set out_valid=1, go to DRAIN.
- DRAIN: when out_ready=1, clear out_valid and go to IDLE.
- done goes high for one cycle in the cycle after the final LOAD write, or after the final DRAIN handshake.
- start is ignored while busy.
- rf_WriteEN is 0 in every state except LOAD.
- out_data holds its value while out_valid=0 or out_ready=0.
- rf_Write_Address, rf_Write_Data and rf_Read_Address always show idx and in_data, even when not in use.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0x00, rf_WriteEN=0, rf_Write_Address=0, rf_Write_Data=in_data, rf_Read_Address=0. State is IDLE, idx=0, csum=0.
- Reset mid-operation aborts to IDLE with no done pulse.
  - Registers already written keep their new values.
  - A byte pending on out_valid is dropped.
- start accepted at cycle S:
  - busy=1 from S+1.
  - LOAD: writes may begin at S+1, one per cycle while in_valid=1.
  - DUMP: first out_valid=1 at S+2.
- With out_ready held at 1, DUMP emits one byte per cycle with no bubbles: 8 bytes, or 9 with the checksum.
- Write latency: data is in the register file at the clock edge of the handshake.
- Simultaneous final handshake and start: start is ignored because state is not yet IDLE.
- After wrap (idx=7), idx returns to 0 with the state change.

## Configuration
- Macro: REGFILE_STREAM_CSUM_EN.
- Defined: the CSUM state exists, and DUMP emits a 9th byte equal to the XOR of the 8 register bytes.
- Undefined: no CSUM state and no csum register; DUMP emits exactly 8 bytes and goes straight to DRAIN.
- LOAD behaviour is identical in both builds.

## Test plan
- LOAD bytes 0x11,0x22,…,0x88 with in_valid held at 1 -> 8 consecutive writes to addresses 0..7, done pulse one cycle after the 8th write, busy low that cycle.
- Then DUMP with out_ready=1 -> out_data 0x11..0x88 in consecutive cycles starting at S+2; with the macro, a 9th byte 0x88 (XOR), then done.
- DUMP with out_ready toggling 1,0,0,1 -> out_data and out_valid stable while out_ready=0; no byte lost or duplicated; order still 0x11..0x88.
- LOAD with in_valid gaps of 2 cycles -> rf_WriteEN only on valid cycles; addresses stay contiguous 0..7.
- Pulse start with mode=0 during a DUMP -> ignored; DUMP completes normally; no LOAD occurs.
- Assert RST after the 3rd DUMP byte -> next cycle out_valid=0, busy=0, no done pulse; a new DUMP restarts from register 0.

Source files
------------

// File: rtl/regfile_stream_port.sv
// Bulk LOAD/DUMP sequencer for the 8x8 register file over valid/ready byte streams.
// Define REGFILE_STREAM_CSUM_EN to append an XOR checksum byte after every DUMP.
module regfile_stream_port (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       rf_WriteEN,
  output logic [2:0] rf_Write_Address,
  output logic [7:0] rf_Write_Data,
  output logic [2:0] rf_Read_Address,
  input  logic [7:0] rf_Read_Data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DUMP  = 3'd2,
`ifdef REGFILE_STREAM_CSUM_EN
    CSUM  = 3'd3,
`endif
    DRAIN = 3'd4
  } state_t;

`ifdef REGFILE_STREAM_CSUM_EN
  localparam state_t AFTER_DUMP = CSUM;
`else
  localparam state_t AFTER_DUMP = DRAIN;
`endif

  state_t     state;
  state_t     state_next;
  logic [2:0] idx;
  logic       slot_free;
  logic       load_last;
  logic       dump_take;
  logic       drain_hs;

  // The output register can take a new byte when it is empty or being consumed this cycle.
  assign slot_free = !out_valid || out_ready;
  assign load_last = (state == LOAD) && in_valid && (idx == 3'd7);
  assign dump_take = (state == DUMP) && slot_free;
  assign drain_hs  = (state == DRAIN) && out_ready;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = mode ? DUMP : LOAD;
      LOAD:    if (load_last) state_next = IDLE;
      DUMP:    if (dump_take && idx == 3'd7) state_next = AFTER_DUMP;
`ifdef REGFILE_STREAM_CSUM_EN
      CSUM:    if (slot_free) state_next = DRAIN;
`endif
      DRAIN:   if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state != IDLE);
    in_ready         = (state == LOAD);
    rf_WriteEN       = (state == LOAD) && in_valid;
    rf_Write_Address = idx;
    rf_Write_Data    = in_data;
    rf_Read_Address  = idx;
  end

`ifdef REGFILE_STREAM_CSUM_EN
  logic [7:0] csum;

  always_ff @(posedge CLK) begin
    if (RST)                            csum <= 8'h00;
    else if (state == IDLE && start)    csum <= 8'h00;
    else if (dump_take)                 csum <= csum ^ rf_Read_Data;
  end
`endif

  // idx wraps from 7 back to 0 on its own, which lines up with the state change.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx       <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      done      <= 1'b0;
    end else begin
      done <= load_last || drain_hs;
      case (state)
        IDLE: if (start) idx <= 3'd0;
        LOAD: if (in_valid) idx <= idx + 3'd1;
        DUMP: if (slot_free) begin
          out_data  <= rf_Read_Data;
          out_valid <= 1'b1;
          idx       <= idx + 3'd1;
        end
`ifdef REGFILE_STREAM_CSUM_EN
        CSUM: if (slot_free) begin
          out_data  <= csum;
          out_valid <= 1'b1;
        end
`endif
        DRAIN: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_stream_port.sv
// Randomized bench: transaction-level model of register contents, the expected write
// sequence and the expected output byte stream, checked every cycle on the falling edge.
`timescale 1ns/1ps
module tb_regfile_stream_port;

`ifdef REGFILE_STREAM_CSUM_EN
  localparam int NBYTES = 9;
`else
  localparam int NBYTES = 8;
`endif

  logic       clk = 1'b0;
  logic       RST;
  logic       start;
  logic       mode;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       rf_WriteEN;
  logic [2:0] rf_Write_Address;
  logic [7:0] rf_Write_Data;
  logic [2:0] rf_Read_Address;
  logic [7:0] rf_Read_Data;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  logic [7:0] rf [8] = '{default: 8'h00};
  logic [7:0] model_regs [8];
  wr_t        exp_wr [$];
  logic [7:0] exp_out [$];
  logic [7:0] seen_out [$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_out = 0;
  bit         done_exp = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  regfile_stream_port dut (
    .CLK              (clk),
    .RST              (RST),
    .start            (start),
    .mode             (mode),
    .busy             (busy),
    .done             (done),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready),
    .rf_WriteEN       (rf_WriteEN),
    .rf_Write_Address (rf_Write_Address),
    .rf_Write_Data    (rf_Write_Data),
    .rf_Read_Address  (rf_Read_Address),
    .rf_Read_Data     (rf_Read_Data)
  );

  // Behavioural register file the block drives.
  assign rf_Read_Data = rf[rf_Read_Address];
  always @(posedge clk) if (rf_WriteEN) rf[rf_Write_Address] <= rf_Write_Data;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs only change 1ns after a rising edge, so falling-edge values are what the next edge sees.
  always @(negedge clk) begin : compare
    wr_t        w;
    logic [7:0] b;
    if (RST) begin
      exp_wr.delete();
      exp_out.delete();
      done_exp  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      check_output("done_pulse", done, done_exp);
      if (done_exp) check_output("busy_at_done", busy, 1'b0);
      done_exp = 1'b0;
      if (prev_hold) begin
        check_output("hold_valid", out_valid, 1'b1);
        check_output("hold_data", out_data, prev_data);
      end
      check_output("wr_en", rf_WriteEN, in_valid && in_ready);
      check_output("wr_data_follows", rf_Write_Data, in_data);
      if (in_ready) check_output("in_ready_outside_load", exp_wr.size() > 0, 1'b1);
      if (rf_WriteEN) begin
        check_output("write_expected", exp_wr.size() > 0, 1'b1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          check_output("wr_addr", rf_Write_Address, w.addr);
          check_output("wr_data", rf_Write_Data, w.data);
          if (exp_wr.size() == 0) done_exp = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        seen_out.push_back(out_data);
        check_output("byte_expected", exp_out.size() > 0, 1'b1);
        if (exp_out.size() > 0) begin
          b = exp_out.pop_front();
          check_output("out_byte", out_data, b);
          if (exp_out.size() == 0) done_exp = 1'b1;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic apply_stimulus_idle(input int n);
    repeat (n) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic start_cmd(input logic m);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'($urandom_range(0, 1));
  endtask

  // kind 0: bytes 0x11..0x88; otherwise random. gap < 0 picks a random gap per byte.
  task automatic apply_stimulus_load(input int kind, input int gap);
    wr_t w;
    int  g;
    for (int i = 0; i < 8; i++) begin
      model_regs[i] = (kind == 0) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      w.addr = 3'(i);
      w.data = model_regs[i];
      exp_wr.push_back(w);
    end
    in_valid = 1'b0;
    start_cmd(1'b0);
    for (int i = 0; i < 8; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = model_regs[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    @(negedge clk); #1;
    check_output("load_all_written", exp_wr.size(), 0);
    @(posedge clk); #1;
  endtask

  // ready_kind 0: always ready, 1: pattern 1,0,0,1, else random.
  task automatic apply_stimulus_dump(input int ready_kind, input bit poke_start, input int abort_after);
    logic [7:0] x;
    int         base;
    bit         fin;
    bit         aborted;
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      exp_out.push_back(model_regs[i]);
      x ^= model_regs[i];
    end
`ifdef REGFILE_STREAM_CSUM_EN
    exp_out.push_back(x);
`endif
    seen_out.delete();
    base    = n_out;
    fin     = 1'b0;
    aborted = 1'b0;
    in_valid = 1'b0;
    start_cmd(1'b1);
    for (int c = 0; c < 300 && !fin && !aborted; c++) begin
      case (ready_kind)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = poke_start && (c == 4);
      mode  = 1'b0;
      @(negedge clk); #1;
      if (c == 0) begin
        check_output("dump_s1_valid", out_valid, 1'b0);
        check_output("dump_s1_busy", busy, 1'b1);
      end
      if (c == 1) check_output("dump_s2_valid", out_valid, 1'b1);
      if (abort_after > 0 && n_out - base >= abort_after) aborted = 1'b1;
      else if (exp_out.size() == 0) fin = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (aborted) begin
      RST = 1'b1;
      @(posedge clk); #1;
      RST = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check_output("abort_out_valid", out_valid, 1'b0);
      check_output("abort_busy", busy, 1'b0);
      check_output("abort_done", done, 1'b0);
      @(posedge clk); #1;
    end else begin
      check_output("dump_all_bytes", exp_out.size(), 0);
      out_ready = 1'b0;
      @(negedge clk); #1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t expected below 500000", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b1; start = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_data = 8'h5A; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    RST = 1'b0;
    @(negedge clk);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_done", done, 1'b0);
    check_output("rst_in_ready", in_ready, 1'b0);
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_out_data", out_data, 8'h00);
    check_output("rst_wr_en", rf_WriteEN, 1'b0);
    check_output("rst_wr_addr", rf_Write_Address, 3'd0);
    check_output("rst_wr_data", rf_Write_Data, 8'h5A);
    check_output("rst_rd_addr", rf_Read_Address, 3'd0);
    @(posedge clk); #1;

    apply_stimulus_load(0, 0);
    check_output("pin_model_reg3", model_regs[3], 8'h44);
    check_output("pin_rf_reg7", rf[7], 8'h88);
    apply_stimulus_dump(0, 1'b0, 0);
    check_output("pin_byte_count", seen_out.size(), NBYTES);
    check_output("pin_first_byte", seen_out[0], 8'h11);
    check_output("pin_last_byte", seen_out[NBYTES-1], 8'h88);

    apply_stimulus_dump(1, 1'b0, 0);
    check_output("pin_toggle_byte4", seen_out[4], 8'h55);
    apply_stimulus_idle(3);
    apply_stimulus_load(1, 2);
    apply_stimulus_idle(2);
    apply_stimulus_dump(2, 1'b1, 0);
    apply_stimulus_dump(0, 1'b0, 3);
    apply_stimulus_dump(0, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      apply_stimulus_idle(int'($urandom_range(1, 4)));
      apply_stimulus_load(1, -1);
      apply_stimulus_idle(int'($urandom_range(1, 4)));
      apply_stimulus_dump(2, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
